// File: rtl/fetch_pkg.sv
// Shared types and constants for the fetch PC generator and its predictor.
package fetch_pkg;

    localparam int FETCH_ADDR_W  = 32;
    localparam int FETCH_INSTR_W = 32;

    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;

    // One instruction FIFO entry; its width sets the FIFO ENTRY_WIDTH.
    typedef struct packed {
        logic [FETCH_INSTR_W-1:0] instr;
        logic [FETCH_ADDR_W-1:0]  pc;
        logic                     pred_taken;
        logic [FETCH_ADDR_W-1:0]  target_pc;
    } fetch_entry_t;

    localparam int ENTRY_WIDTH = $bits(fetch_entry_t);

    typedef enum logic {
        FETCH,
        MISS_WAIT
    } fetch_state_e;

endpackage

// File: rtl/fetch_pc_gen_if.sv
// Icache lookup, FIFO enqueue and backend redirect signals of the fetch stage.
interface fetch_pc_gen_if #(
    parameter int ADDR_WIDTH  = 32,
    parameter int INSTR_WIDTH = 32
);
    logic [ADDR_WIDTH-1:0]  icache_addr;
    logic                   icache_req;
    logic                   icache_hit;
    logic [INSTR_WIDTH-1:0] icache_instr;
    logic                   icache_refill_done;
    logic                   enq_valid;
    logic                   enq_ready;
    logic [INSTR_WIDTH-1:0] enq_instr;
    logic [ADDR_WIDTH-1:0]  enq_pc;
    logic                   enq_pred_taken;
    logic [ADDR_WIDTH-1:0]  enq_target_pc;
    logic                   redirect_valid;
    logic [ADDR_WIDTH-1:0]  redirect_pc;

    // master = fetch stage; slave = icache, FIFO and backend around it
    modport master (
        output icache_addr, icache_req, enq_valid, enq_instr, enq_pc,
               enq_pred_taken, enq_target_pc,
        input  icache_hit, icache_instr, icache_refill_done, enq_ready,
               redirect_valid, redirect_pc
    );

    modport slave (
        input  icache_addr, icache_req, enq_valid, enq_instr, enq_pc,
               enq_pred_taken, enq_target_pc,
        output icache_hit, icache_instr, icache_refill_done, enq_ready,
               redirect_valid, redirect_pc
    );
endinterface

// File: rtl/static_branch_predictor.sv
// Combinational static predictor: JAL taken, backward branches taken, rest fall through.
module static_branch_predictor
    import fetch_pkg::*;
#(
    parameter int ADDR_WIDTH  = FETCH_ADDR_W,
    parameter int INSTR_WIDTH = FETCH_INSTR_W
) (
    input  logic [INSTR_WIDTH-1:0] instr_i,
    input  logic [ADDR_WIDTH-1:0]  pc_i,
    output logic                   pred_taken_o,
    output logic [ADDR_WIDTH-1:0]  target_pc_o
);
    logic [20:0]           j_imm;
    logic [12:0]           b_imm;
    logic [ADDR_WIDTH-1:0] j_off;
    logic [ADDR_WIDTH-1:0] b_off;

    assign j_imm = {instr_i[31], instr_i[19:12], instr_i[20], instr_i[30:21], 1'b0};
    assign b_imm = {instr_i[31], instr_i[7], instr_i[30:25], instr_i[11:8], 1'b0};
    assign j_off = {{(ADDR_WIDTH-21){j_imm[20]}}, j_imm};
    assign b_off = {{(ADDR_WIDTH-13){b_imm[12]}}, b_imm};

    always_comb begin
        pred_taken_o = 1'b0;
        target_pc_o  = pc_i + ADDR_WIDTH'(4);
        if (instr_i[6:0] == OP_JAL) begin
            pred_taken_o = 1'b1;
            target_pc_o  = pc_i + j_off;
        end else if (instr_i[6:0] == OP_BRANCH && instr_i[31]) begin
            pred_taken_o = 1'b1;
            target_pc_o  = pc_i + b_off;
        end
    end
endmodule

// File: rtl/fetch_pc_gen.sv
// Fetch PC owner: looks up the icache, predicts the next PC and enqueues hits into the FIFO.
module fetch_pc_gen
    import fetch_pkg::*;
#(
    parameter int                    ADDR_WIDTH  = FETCH_ADDR_W,
    parameter int                    INSTR_WIDTH = FETCH_INSTR_W,
    parameter logic [ADDR_WIDTH-1:0] RESET_PC    = '0
) (
    input  logic           clk,
    input  logic           rst,
    fetch_pc_gen_if.master fe
);
    fetch_state_e          state_q, state_d;
    logic [ADDR_WIDTH-1:0] pc_q, pc_d;
    logic                  pred_taken;
    logic [ADDR_WIDTH-1:0] target_pc;
    logic                  req;
    logic                  valid;

    static_branch_predictor #(
        .ADDR_WIDTH  (ADDR_WIDTH),
        .INSTR_WIDTH (INSTR_WIDTH)
    ) u_bp (
        .instr_i      (fe.icache_instr),
        .pc_i         (pc_q),
        .pred_taken_o (pred_taken),
        .target_pc_o  (target_pc)
    );

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        req     = 1'b0;
        valid   = 1'b0;
        if (rst) begin
            state_d = FETCH;
        end else if (fe.redirect_valid) begin
            // Redirect wins over everything, including a same-cycle refill.
            req     = (state_q == FETCH);
            state_d = FETCH;
            pc_d    = fe.redirect_pc;
        end else begin
            unique case (state_q)
                FETCH: begin
                    req = 1'b1;
                    if (fe.icache_hit) begin
                        valid = 1'b1;
                        if (fe.enq_ready) pc_d = target_pc;
                    end else begin
                        state_d = MISS_WAIT;
                    end
                end
                MISS_WAIT: begin
                    if (fe.icache_refill_done) state_d = FETCH;
                end
                default: state_d = FETCH;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= FETCH;
            pc_q    <= RESET_PC;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
        end
    end

    assign fe.icache_addr    = pc_q;
    assign fe.icache_req     = req;
    assign fe.enq_valid      = valid;
    assign fe.enq_instr      = fe.icache_instr;
    assign fe.enq_pc         = pc_q;
    assign fe.enq_pred_taken = pred_taken;
    assign fe.enq_target_pc  = target_pc;
endmodule

// File: tb/tb_fetch_pc_gen.sv
// Bench for fetch_pc_gen: directed scenarios plus randomized traffic against a behavioural model.
module tb_fetch_pc_gen;
    import fetch_pkg::*;

    localparam logic [31:0] RST_PC = 32'h0000_0100;
    localparam logic [31:0] ADDI   = 32'h0010_8093;
    localparam logic [31:0] JALR   = 32'h0000_80E7;

    logic clk;
    logic rst;
    int   checks;
    int   errors;

    fetch_pc_gen_if #(.ADDR_WIDTH(32), .INSTR_WIDTH(32)) bus ();

    fetch_pc_gen #(
        .ADDR_WIDTH  (32),
        .INSTR_WIDTH (32),
        .RESET_PC    (RST_PC)
    ) dut (
        .clk (clk),
        .rst (rst),
        .fe  (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] enc_b(input int imm);
        logic [12:0] i;
        i = imm[12:0];
        return {i[12], i[10:5], 5'd2, 5'd1, 3'b000, i[4:1], i[11], 7'b1100011};
    endfunction

    function automatic logic [31:0] enc_j(input int imm);
        logic [20:0] i;
        i = imm[20:0];
        return {i[20], i[10:1], i[11], i[19:12], 5'd1, 7'b1101111};
    endfunction

    // Reference prediction: immediates rebuilt as signed integer sums of their bit fields.
    function automatic fetch_entry_t model_entry(input logic [31:0] instr, input logic [31:0] pc);
        fetch_entry_t e;
        int off;
        e.instr      = instr;
        e.pc         = pc;
        e.pred_taken = 1'b0;
        e.target_pc  = pc + 32'd4;
        if (instr[6:0] == 7'b1101111) begin
            off = (instr[31] ? -1048576 : 0) + 4096 * int'(instr[19:12])
                + 2048 * int'(instr[20]) + 2 * int'(instr[30:21]);
            e.pred_taken = 1'b1;
            e.target_pc  = pc + 32'(off);
        end else if (instr[6:0] == 7'b1100011 && instr[31]) begin
            off = -4096 + 2048 * int'(instr[7]) + 32 * int'(instr[30:25])
                + 2 * int'(instr[11:8]);
            e.pred_taken = 1'b1;
            e.target_pc  = pc + 32'(off);
        end
        return e;
    endfunction

    task automatic drive(input logic hit, input logic [31:0] instr, input logic ready,
                         input logic refill, input logic redir, input logic [31:0] rpc);
        bus.icache_hit         = hit;
        bus.icache_instr       = instr;
        bus.enq_ready          = ready;
        bus.icache_refill_done = refill;
        bus.redirect_valid     = redir;
        bus.redirect_pc        = rpc;
        #1;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic go_to(input logic [31:0] pc);
        drive(1'b0, ADDI, 1'b1, 1'b0, 1'b1, pc);
        tick();
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(1'b1, ADDI, 1'b1, 1'b0, 1'b0, 32'h0);
        checks++; if (bus.icache_req !== 1'b0) begin errors++; $display("FAIL reset_req: got %b exp 0", bus.icache_req); end
        checks++; if (bus.enq_valid !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b exp 0", bus.enq_valid); end
        tick();
        rst = 1'b0;
        drive(1'b1, ADDI, 1'b1, 1'b0, 1'b0, 32'h0);
        checks++; if (bus.icache_addr !== RST_PC) begin errors++; $display("FAIL reset_addr: got %h exp %h", bus.icache_addr, RST_PC); end
        checks++; if (bus.icache_req !== 1'b1) begin errors++; $display("FAIL reset_req_after: got %b exp 1", bus.icache_req); end
    endtask

    task automatic test_sequential();
        for (int i = 0; i < 3; i++) begin
            logic [31:0] pc;
            pc = RST_PC + 32'(4 * i);
            drive(1'b1, ADDI, 1'b1, 1'b0, 1'b0, 32'h0);
            checks++; if (bus.enq_valid !== 1'b1) begin errors++; $display("FAIL seq_valid[%0d]: got %b exp 1", i, bus.enq_valid); end
            checks++; if (bus.enq_pc !== pc) begin errors++; $display("FAIL seq_pc[%0d]: got %h exp %h", i, bus.enq_pc, pc); end
            checks++; if (bus.enq_pred_taken !== 1'b0) begin errors++; $display("FAIL seq_taken[%0d]: got %b exp 0", i, bus.enq_pred_taken); end
            checks++; if (bus.enq_target_pc !== pc + 32'd4) begin errors++; $display("FAIL seq_target[%0d]: got %h exp %h", i, bus.enq_target_pc, pc + 32'd4); end
            checks++; if (bus.enq_instr !== ADDI) begin errors++; $display("FAIL seq_instr[%0d]: got %h exp %h", i, bus.enq_instr, ADDI); end
            tick();
        end
    endtask

    task automatic test_branch();
        go_to(32'h200);
        drive(1'b1, enc_b(-16), 1'b1, 1'b0, 1'b0, 32'h0);
        checks++; if (bus.enq_pred_taken !== 1'b1) begin errors++; $display("FAIL bwd_taken: got %b exp 1", bus.enq_pred_taken); end
        checks++; if (bus.enq_target_pc !== 32'h1F0) begin errors++; $display("FAIL bwd_target: got %h exp 1f0", bus.enq_target_pc); end
        tick();
        checks++; if (bus.icache_addr !== 32'h1F0) begin errors++; $display("FAIL bwd_next_addr: got %h exp 1f0", bus.icache_addr); end
        go_to(32'h200);
        drive(1'b1, enc_b(16), 1'b1, 1'b0, 1'b0, 32'h0);
        checks++; if (bus.enq_pred_taken !== 1'b0) begin errors++; $display("FAIL fwd_taken: got %b exp 0", bus.enq_pred_taken); end
        checks++; if (bus.enq_target_pc !== 32'h204) begin errors++; $display("FAIL fwd_target: got %h exp 204", bus.enq_target_pc); end
        tick();
    endtask

    task automatic test_jal();
        go_to(32'h300);
        drive(1'b1, enc_j(32'h800), 1'b1, 1'b0, 1'b0, 32'h0);
        checks++; if (bus.enq_pred_taken !== 1'b1) begin errors++; $display("FAIL jal_taken: got %b exp 1", bus.enq_pred_taken); end
        checks++; if (bus.enq_target_pc !== 32'hB00) begin errors++; $display("FAIL jal_target: got %h exp b00", bus.enq_target_pc); end
        tick();
        checks++; if (bus.icache_addr !== 32'hB00) begin errors++; $display("FAIL jal_next_addr: got %h exp b00", bus.icache_addr); end
        go_to(32'h304);
        drive(1'b1, JALR, 1'b1, 1'b0, 1'b0, 32'h0);
        checks++; if (bus.enq_pred_taken !== 1'b0) begin errors++; $display("FAIL jalr_taken: got %b exp 0", bus.enq_pred_taken); end
        checks++; if (bus.enq_target_pc !== 32'h308) begin errors++; $display("FAIL jalr_target: got %h exp 308", bus.enq_target_pc); end
        tick();
    endtask

    task automatic test_stall();
        go_to(32'h400);
        for (int c = 0; c < 3; c++) begin
            drive(1'b1, ADDI, 1'b0, 1'b0, 1'b0, 32'h0);
            checks++; if (bus.enq_valid !== 1'b1) begin errors++; $display("FAIL stall_valid[%0d]: got %b exp 1", c, bus.enq_valid); end
            checks++; if (bus.icache_addr !== 32'h400 || bus.enq_pc !== 32'h400) begin errors++; $display("FAIL stall_pc[%0d]: got %h/%h exp 400", c, bus.icache_addr, bus.enq_pc); end
            checks++; if (bus.enq_target_pc !== 32'h404 || bus.enq_instr !== ADDI) begin errors++; $display("FAIL stall_fields[%0d]: got %h/%h exp 404/%h", c, bus.enq_target_pc, bus.enq_instr, ADDI); end
            tick();
        end
        drive(1'b1, ADDI, 1'b1, 1'b0, 1'b0, 32'h0);
        checks++; if (bus.enq_valid !== 1'b1) begin errors++; $display("FAIL stall_release_valid: got %b exp 1", bus.enq_valid); end
        tick();
        checks++; if (bus.icache_addr !== 32'h404) begin errors++; $display("FAIL stall_next_addr: got %h exp 404", bus.icache_addr); end
    endtask

    task automatic test_miss();
        go_to(32'h500);
        drive(1'b0, ADDI, 1'b1, 1'b0, 1'b0, 32'h0);
        checks++; if (bus.icache_req !== 1'b1 || bus.enq_valid !== 1'b0) begin errors++; $display("FAIL miss_detect: got req=%b valid=%b exp 1/0", bus.icache_req, bus.enq_valid); end
        tick();
        for (int c = 0; c < 5; c++) begin
            drive(1'b1, ADDI, 1'b1, 1'b0, 1'b0, 32'h0);
            checks++; if (bus.icache_req !== 1'b0 || bus.enq_valid !== 1'b0) begin errors++; $display("FAIL miss_wait[%0d]: got req=%b valid=%b exp 0/0", c, bus.icache_req, bus.enq_valid); end
            tick();
        end
        drive(1'b0, ADDI, 1'b1, 1'b1, 1'b0, 32'h0);
        tick();
        drive(1'b1, ADDI, 1'b1, 1'b0, 1'b0, 32'h0);
        checks++; if (bus.icache_req !== 1'b1 || bus.icache_addr !== 32'h500) begin errors++; $display("FAIL miss_refetch: got req=%b addr=%h exp 1/500", bus.icache_req, bus.icache_addr); end
        checks++; if (bus.enq_valid !== 1'b1 || bus.enq_pc !== 32'h500) begin errors++; $display("FAIL miss_enq: got valid=%b pc=%h exp 1/500", bus.enq_valid, bus.enq_pc); end
        tick();
        checks++; if (bus.icache_addr !== 32'h504) begin errors++; $display("FAIL miss_next_addr: got %h exp 504", bus.icache_addr); end
    endtask

    task automatic test_redirect();
        drive(1'b1, ADDI, 1'b1, 1'b0, 1'b1, 32'h800);
        checks++; if (bus.enq_valid !== 1'b0) begin errors++; $display("FAIL redir_kill: got %b exp 0", bus.enq_valid); end
        tick();
        checks++; if (bus.icache_addr !== 32'h800) begin errors++; $display("FAIL redir_addr: got %h exp 800", bus.icache_addr); end
        drive(1'b1, ADDI, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b0, ADDI, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        drive(1'b0, ADDI, 1'b1, 1'b1, 1'b1, 32'h800);
        tick();
        drive(1'b1, ADDI, 1'b1, 1'b0, 1'b0, 32'h0);
        checks++; if (bus.icache_req !== 1'b1 || bus.icache_addr !== 32'h800) begin errors++; $display("FAIL redir_miss: got req=%b addr=%h exp 1/800", bus.icache_req, bus.icache_addr); end
        tick();
    endtask

    task automatic test_reset_mid_miss();
        go_to(32'h600);
        drive(1'b0, ADDI, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        rst = 1'b1;
        drive(1'b0, ADDI, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        rst = 1'b0;
        drive(1'b1, ADDI, 1'b1, 1'b1, 1'b0, 32'h0);
        checks++; if (bus.icache_req !== 1'b1 || bus.icache_addr !== RST_PC || bus.enq_valid !== 1'b1) begin errors++; $display("FAIL rst_mid_miss: got req=%b addr=%h valid=%b exp 1/%h/1", bus.icache_req, bus.icache_addr, bus.enq_valid, RST_PC); end
        tick();
        checks++; if (bus.icache_addr !== RST_PC + 32'd4) begin errors++; $display("FAIL rst_stale_refill: got %h exp %h", bus.icache_addr, RST_PC + 32'd4); end
    endtask

    task automatic test_random();
        logic [31:0] m_pc;
        bit          m_wait;
        rst = 1'b1;
        drive(1'b0, ADDI, 1'b1, 1'b0, 1'b0, 32'h0);
        tick();
        rst    = 1'b0;
        m_pc   = RST_PC;
        m_wait = 1'b0;
        for (int n = 0; n < 400; n++) begin
            logic [31:0]  instr, rpc;
            logic         hit, ready, refill, redir, exp_req, exp_valid;
            fetch_entry_t exp;
            instr  = $urandom;
            case ($urandom_range(0, 2))
                0:       instr[6:0] = 7'b1101111;
                1:       instr[6:0] = 7'b1100011;
                default: ;
            endcase
            rst    = ($urandom_range(0, 99) < 2);
            hit    = ($urandom_range(0, 3) != 0);
            ready  = ($urandom_range(0, 2) != 0);
            refill = ($urandom_range(0, 4) == 0);
            redir  = ($urandom_range(0, 11) == 0);
            rpc    = (n % 50 == 0) ? 32'hFFFF_FFF8 : ($urandom & 32'hFFFF_FFFC);
            drive(hit, instr, ready, refill, redir, rpc);
            exp_req   = !rst && !m_wait;
            exp_valid = exp_req && hit && !redir;
            exp       = model_entry(instr, m_pc);
            checks++; if (bus.icache_addr !== m_pc) begin errors++; $display("FAIL rnd_addr[%0d]: got %h exp %h", n, bus.icache_addr, m_pc); end
            checks++; if (bus.icache_req !== exp_req) begin errors++; $display("FAIL rnd_req[%0d]: got %b exp %b", n, bus.icache_req, exp_req); end
            checks++; if (bus.enq_valid !== exp_valid) begin errors++; $display("FAIL rnd_valid[%0d]: got %b exp %b", n, bus.enq_valid, exp_valid); end
            if (exp_valid) begin
                checks++;
                if ({bus.enq_instr, bus.enq_pc, bus.enq_pred_taken, bus.enq_target_pc} !== exp) begin
                    errors++;
                    $display("FAIL rnd_entry[%0d]: got %h/%h/%b/%h exp %h/%h/%b/%h", n, bus.enq_instr, bus.enq_pc,
                             bus.enq_pred_taken, bus.enq_target_pc, exp.instr, exp.pc, exp.pred_taken, exp.target_pc);
                end
            end
            tick();
            if (rst) begin
                m_pc = RST_PC; m_wait = 1'b0;
            end else if (redir) begin
                m_pc = rpc; m_wait = 1'b0;
            end else if (m_wait) begin
                if (refill) m_wait = 1'b0;
            end else if (!hit) begin
                m_wait = 1'b1;
            end else if (ready) begin
                m_pc = exp.target_pc;
            end
        end
        rst = 1'b0;
    endtask

    initial begin
        checks = 0;
        errors = 0;
        rst    = 1'b0;
        test_reset();
        test_sequential();
        test_branch();
        test_jal();
        test_stall();
        test_miss();
        test_redirect();
        test_reset_mid_miss();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/fetch_pc_gen.md
Name: fetch_pc_gen

Overview:
- Fetch stage directly upstream of the instruction FIFO.
- Owns the fetch PC and presents it to the icache each cycle.
- On an icache hit, statically predicts the next PC and enqueues {instruction, PC, pred_taken, target_pc} into the FIFO with a valid/ready handshake.
- Handles icache-miss waits, FIFO-full back-pressure, and backend redirects (mispredict/exception).

Parameters:
- ADDR_WIDTH, 32, PC / target width.
- INSTR_WIDTH, 32, instruction width.
- RESET_PC, 32'h0000_0000, fetch PC loaded on reset.

Ports:
- clk  in  1  clock.
- rst  in  1  reset; one clock, synchronous, active-high.
- icache_addr  out  ADDR_WIDTH  lookup address (= pc_q).
- icache_req  out  1  lookup valid.
- icache_hit  in  1  same-cycle hit for icache_addr.
- icache_instr  in  INSTR_WIDTH  instruction word, valid when icache_hit.
- icache_refill_done  in  1  one-cycle pulse: miss line filled.
- enq_valid  out  1  FIFO enqueue valid.
- enq_ready  in  1  FIFO not full.
- enq_instr  out  INSTR_WIDTH  instruction.
- enq_pc  out  ADDR_WIDTH  PC of instruction.
- enq_pred_taken  out  1  1 = predicted taken.
- enq_target_pc  out  ADDR_WIDTH  predicted next PC.
- redirect_valid  in  1  backend redirect.
- redirect_pc  in  ADDR_WIDTH  redirect target.

Behaviour:
- State FSM:
  - States: FETCH, MISS_WAIT.
  - Reset: state=FETCH, pc_q=RESET_PC.
  - Output values in reset cycle: icache_req=0, enq_valid=0.
- FETCH:
  - icache_req=1.
  - If icache_hit: enq_valid=1. Enqueue fires when enq_valid&&enq_ready; then pc_q<=enq_target_pc the next edge.
  - If hit but !enq_ready: hold pc_q and all enq_* stable (full stall; no new lookup effect).
  - If !icache_hit: enq_valid=0; go to MISS_WAIT.
- MISS_WAIT:
  - icache_req=0, enq_valid=0.
  - On icache_refill_done go to FETCH and re-look-up the same pc_q.
  - Minimum miss penalty: 1 cycle in MISS_WAIT plus refill latency.
- Redirect (highest priority, any state):
  - enq_valid forced 0 combinationally that cycle.
  - Next edge: pc_q<=redirect_pc, state<=FETCH.
  - A refill_done in the same cycle is ignored.
- Static predictor (combinational, on icache_instr, pc_q):
  - JAL (opcode 7'b1101111): taken, target=pc_q+sext(J-imm).
  - BRANCH (opcode 7'b1100011): taken iff B-imm sign bit (instr[31])=1, i.e. backward branch. Target=pc_q+sext(B-imm) if taken, else pc_q+4.
  - All others, including JALR: not taken, target=pc_q+4.
  - Adds are ADDR_WIDTH-wide and wrap modulo 2^ADDR_WIDTH.
- Enqueue fields:
  - enq_pc=pc_q, enq_instr=icache_instr.
  - The enq_* fields are only meaningful when enq_valid=1.
- Reset mid-miss: returns to FETCH at RESET_PC; stale refill_done pulses in FETCH are ignored.
- Throughput: one instruction per cycle on consecutive hits with enq_ready=1.

Decomposition:
- Shared package fetch_pkg holds:
  - ADDR_WIDTH and INSTR_WIDTH defaults.
  - Opcode constants OP_JAL and OP_BRANCH.
  - fetch_entry_t struct {instr, pc, pred_taken, target_pc}, whose width equals the FIFO ENTRY_WIDTH.
  - FSM state enum.
- One sub-module: static_branch_predictor. It is purely combinational (instr, pc -> pred_taken, target_pc) and is instantiated once.

Test Plan:
- Reset with RESET_PC=0x100, all hits, enq_ready=1, instructions ADDI -> enq_pc sequence 0x100, 0x104, 0x108; pred_taken=0; one enqueue per cycle.
- At 0x200, BEQ with imm=-16 -> enq_pred_taken=1, target=0x1F0, next icache_addr=0x1F0. Same BEQ with imm=+16 -> pred_taken=0, target=0x204.
- At 0x300, JAL imm=+0x800 -> pred_taken=1, target=0xB00. At 0x304, JALR -> pred_taken=0, target=0x308.
- Hit at 0x400, enq_ready=0 for 3 cycles -> enq_valid held high with identical fields, pc_q stays 0x400; enqueue on the 4th cycle, then 0x404.
- Miss at 0x500 -> MISS_WAIT, icache_req=0, enq_valid=0. refill_done pulse after 5 cycles -> refetch 0x500, hit, enqueue.
- redirect_valid with redirect_pc=0x800, asserted during a hit with enq_ready=1 -> no enqueue that cycle, next icache_addr=0x800. Same during MISS_WAIT with a simultaneous refill_done -> FETCH at 0x800.
